mul8x8_seq_ctrl: RTL
====================

# mul8x8_seq_ctrl

Sequential 8x8 unsigned multiplier controller that time-multiplexes one gate-level 4x4 multiplier instance, `Multiplier_4x4_8bits_in_nor`, across four nibble partial products and accumulates them into a 16-bit result. It sits between an upstream operand producer and a downstream result consumer. Both sides use valid/ready handshakes. It is the team's area-saving path to 8-bit products without building a full 8x8 NOR array.

## Interface
- `ZERO_SKIP`, default 0: when 1, an accepted operand pair with `a==0` or `b==0` bypasses the multiply steps.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands (combinational, equals state==IDLE).
- `a`  in  8  multiplicand, unsigned.
- `b`  in  8  multiplier, unsigned.
- `out_valid`  out  1  `product` holds a final result.
- `out_ready`  in  1  consumer accepts the result.
- `product`  out  16  accumulator register.
- `busy`  out  1  high in state MUL.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL: `step` counter 0..3.
  - DONE: `out_valid`=1.
- IDLE -> MUL on `in_valid && in_ready`:
  - latch `a`/`b` into internal operand registers;
  - clear the accumulator to 0 and `step` to 0.
- With `ZERO_SKIP`=1 and a zero operand, the accepting edge goes IDLE -> DONE instead, with the accumulator cleared to 0.
- Per MUL step, the single 4x4 instance gets the nibbles below, and the result is added to the accumulator:

| step | multiplier inputs | accumulator update |
|---|---|---|
| 0 | aL, bL | acc += p |
| 1 | aL, bH | acc += p<<4 |
| 2 | aH, bL | acc += p<<4 |
| 3 | aH, bH | acc += p<<8 |

- After step 3 the state goes MUL -> DONE.
- DONE -> IDLE on `out_valid && out_ready`. The DONE state never accepts new operands in the same cycle.
- Arithmetic rules:
  - all values are unsigned;
  - 16-bit accumulator; maximum 255*255 = 0xFE01, so no overflow or wrap is possible;
  - shifts are zero-filled.
- Operand registers are frozen during MUL. Input changes and `in_valid` while not IDLE are ignored.
- `product` is stable for the whole time `out_valid` is high. It holds its value in IDLE until the next acceptance clears it.
- Reset, asynchronous, at any time including mid-MUL or in DONE:
  - state = IDLE, `step` = 0, accumulator = 0, operand registers = 0;
  - the in-flight operation is discarded with no output.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0x0000.
- Accept edge E0; steps are registered at edges E1..E4; `out_valid` rises in the cycle after E4.
  - Latency from the accept edge: 4 cycles.
  - With a zero operand and `ZERO_SKIP`=1: 1 cycle.
- `busy` is high in the cycles between E0 and E4.
- Result consumed at edge Ek (`out_valid && out_ready`):
  - `out_valid` falls and `in_ready` rises in the next cycle;
  - the earliest next accept is edge Ek+1.
- Peak throughput with `out_ready` tied high: one result per 6 cycles.
- Back-pressure: `out_valid` stays high and `product` is held indefinitely while `out_ready`=0.
- `in_valid` asserted in the same cycle as `out_valid && out_ready` is not accepted. `in_ready` is 0 that cycle.
- The multiplier path is combinational from operand/step registers to accumulator D-input. The 4x4 NOR array plus a 16-bit adder must close in one cycle.

## Test plan
- Basic product:
  - a=0x12, b=0x34 with `out_ready`=1 -> `out_valid` 4 cycles after accept;
  - `product`=0x03A8; `busy` high exactly 4 cycles.
- Corner values:
  - a=0xFF, b=0xFF -> `product`=0xFE01;
  - a=0x0F, b=0xF0 -> 0x0E10;
  - a=0x01, b=0x01 -> 0x0001.
- Back-pressure and ignored input:
  - hold `out_ready`=0 for 10 cycles after `out_valid` -> `product` is unchanged and `out_valid` stays 1;
  - `in_valid` pulses during MUL/DONE with new a/b are ignored, and `in_ready`=0 throughout;
  - next accept occurs 1 cycle after consumption.
- Mid-operation reset: assert `rst_n`=0 at step 2 of a=0xAB, b=0xCD ->
  - outputs go immediately to `in_ready`=1, `out_valid`=0, `product`=0;
  - after release, a=0x03, b=0x05 yields 0x000F with normal latency.
- Zero skip, `ZERO_SKIP`=1:
  - a=0x00, b=0x7F -> `out_valid` the cycle after accept, `product`=0, `busy` never high;
  - with `ZERO_SKIP`=0 the same input takes 4 cycles and gives 0.
- Random regression: 1000 random pairs with random `out_ready` stalls -> every `product` equals a*b, with no lost or duplicated results.

Source files
------------

// File: rtl/mul8x8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul8x8_seq_ctrl
// Brief    : 8x8 unsigned sequential multiplier sharing one 4x4 NOR-array
//            multiplier over four nibble steps, valid/ready on both sides.
// Revision : 1.0
// ============================================================================

module Multiplier_4x4_8bits_in_nor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0][3:0] w_pp;

    // AND of each bit pair realised as NOR of the complemented inputs
    for (genvar i = 0; i < 4; i++) begin : g_pp_row
        for (genvar j = 0; j < 4; j++) begin : g_pp_col
            assign w_pp[i][j] = ~((~a[j]) | (~b[i]));
        end
    end

    assign p = {4'b0000, w_pp[0]}
             + {3'b000,  w_pp[1], 1'b0}
             + {2'b00,   w_pp[2], 2'b00}
             + {1'b0,    w_pp[3], 3'b000};
endmodule

module mul8x8_seq_ctrl #(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_step;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic        w_accept;
    logic        w_zero_op;
    logic [3:0]  w_mul_a;
    logic [3:0]  w_mul_b;
    logic [7:0]  w_mul_p;
    logic [15:0] w_addend;

    assign w_accept  = in_valid && (r_state == c_IDLE);
    assign w_zero_op = (a == 8'h00) || (b == 8'h00);

    // step[1] picks the a nibble, step[0] picks the b nibble
    assign w_mul_a = r_step[1] ? r_a[7:4] : r_a[3:0];
    assign w_mul_b = r_step[0] ? r_b[7:4] : r_b[3:0];

    Multiplier_4x4_8bits_in_nor u_mul4 (
        .a (w_mul_a),
        .b (w_mul_b),
        .p (w_mul_p)
    );

    always_comb begin
        w_addend = 16'h0000;
        case (r_step)
            2'd0:    w_addend = {8'h00, w_mul_p};
            2'd1,
            2'd2:    w_addend = {4'h0, w_mul_p, 4'h0};
            default: w_addend = {w_mul_p, 8'h00};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (ZERO_SKIP && w_zero_op) ? c_DONE : c_MUL;
                end
            end
            c_MUL: begin
                if (r_step == 2'd3) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            c_IDLE:  in_ready  = 1'b1;
            c_MUL:   busy      = 1'b1;
            c_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_acc  <= 16'h0000;
            r_step <= 2'd0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= 16'h0000;
            r_step <= 2'd0;
        end else if (r_state == c_MUL) begin
            r_acc  <= r_acc + w_addend;
            r_step <= r_step + 2'd1;
        end
    end

    assign product = r_acc;

endmodule
`default_nettype wire
